// File: rtl/mult_sequencer.sv
// mult_sequencer: queues unsigned 16x16 operand pairs and runs them one at a
// time through an external multiplier. Each run clears the multiplier, sends
// a start pulse, waits for done and holds the result until it is accepted.
// A pair with a zero operand skips the multiplier and returns 0 directly.
// Optional feature macro: MULT_SEQ_TIMEOUT_EN adds a WAIT watchdog that
// returns out_product=0 with out_err=1 after TIMEOUT_CYCLES WAIT cycles.
//
// state | meaning
// IDLE  | pop the next pair if the FIFO holds one
// CLEAR | mul_res_n low for one cycle
// START | mul_start high for one cycle
// WAIT  | wait for mul_done (ignored in the first WAIT cycle)
// HOLD  | out_valid high until out_ready
module mult_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mul_res_n,
    output logic        mul_start,
    output logic [15:0] mul_arg1,
    output logic [15:0] mul_arg2,
    input  logic        mul_done,
    input  logic [31:0] mul_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        out_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_START, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, pop;
    logic [15:0] head_a, head_b;
    logic [15:0] arg1_q, arg1_d, arg2_q, arg2_d;
    logic [31:0] prod_q, prod_d;
    logic        wait_first_q, wait_first_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    // A pop frees a slot this cycle, so a full FIFO can still take a push.
    assign in_ready   = !fifo_full || pop;
    assign push       = in_valid && in_ready;
    assign {head_a, head_b} = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage, written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Watchdog down-counter and error flag.
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            arg1_q       <= '0;
            arg2_q       <= '0;
            prod_q       <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg1_q       <= arg1_d;
            arg2_q       <= arg2_d;
            prod_q       <= prod_d;
            wait_first_q <= wait_first_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d      = state_q;
        arg1_d       = arg1_q;
        arg2_d       = arg2_q;
        prod_d       = prod_q;
        wait_first_d = wait_first_q;
`ifdef MULT_SEQ_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_a == 16'd0 || head_b == 16'd0) begin
                        prod_d  = '0;
`ifdef MULT_SEQ_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                        state_d = S_HOLD;
                    end else begin
                        arg1_d  = head_a;
                        arg2_d  = head_b;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: state_d = S_START;
            S_START: begin
                wait_first_d = 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
                cnt_d        = CW'(TIMEOUT_CYCLES - 1);
`endif
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                wait_first_d = 1'b0;
                if (!wait_first_q && mul_done) begin
                    prod_d  = mul_product;
`ifdef MULT_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_HOLD;
                end
`ifdef MULT_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mul_res_n   = !(res || state_q == S_CLEAR);
    assign mul_start   = (state_q == S_START);
    assign mul_arg1    = arg1_q;
    assign mul_arg2    = arg2_q;
    assign out_valid   = (state_q == S_HOLD);
    assign out_product = prod_q;

endmodule
